fc_layer_par: RTL

- Parametrised fully-connected layer computing y = act(W·x + b).
- W is M×N, x has N elements, b and y have M elements; all elements are signed T-bit.
- W and b are loaded at run time over the input stream into internal RAMs; weights are not baked into ROMs.
- P MAC lanes compute P outputs concurrently. Optional ReLU and output saturation.
- Sits between valid/ready streaming stages in the layer pipeline.

---
 rtl/fc_layer_par.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/fc_layer_par.sv
`default_nettype none
// ============================================================================
// Module   : fc_layer_par
// Purpose  : Streaming fully-connected layer y = act(W*x + b) using P MAC
//            lanes, with weights and biases loaded at run time.
// Revision : 1.0 - initial release
// ============================================================================

module fc_layer_par #(
    parameter int M    = 13,
    parameter int N    = 16,
    parameter int T    = 32,
    parameter int P    = 1,
    parameter int RELU = 1,
    parameter int SAT  = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_load,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [T-1:0] data_in,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [T-1:0] data_out,
    output logic         w_loaded
);

    localparam int c_groups = M / P;
    localparam int c_aw     = 2 * T + $clog2(N + 1);
    localparam int c_cw     = $clog2(M * N + N + 3);
    localparam int c_waw    = (M * N > 1) ? $clog2(M * N) : 1;
    localparam int c_baw    = (M > 1) ? $clog2(M) : 1;
    localparam int c_xaw    = (N > 1) ? $clog2(N) : 1;
    localparam int c_gw     = (c_groups > 1) ? $clog2(c_groups) : 1;
    localparam int c_pw     = (P > 1) ? $clog2(P) : 1;

    localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
    localparam logic [c_cw-1:0] c_cnt_two  = c_cw'(2);
    localparam logic [c_cw-1:0] c_w_last   = c_cw'(M * N - 1);
    localparam logic [c_cw-1:0] c_b_last   = c_cw'(M - 1);
    localparam logic [c_cw-1:0] c_x_last   = c_cw'(N - 1);
    localparam logic [c_cw-1:0] c_n        = c_cw'(N);
    localparam logic [c_cw-1:0] c_n1       = c_cw'(N + 1);
    localparam logic [c_cw-1:0] c_cmp_last = c_cw'(N + 2);
    localparam logic [c_gw-1:0] c_g_last   = c_gw'(c_groups - 1);
    localparam logic [c_gw-1:0] c_g_one    = c_gw'(1);
    localparam logic [c_pw-1:0] c_p_last   = c_pw'(P - 1);
    localparam logic [c_pw-1:0] c_p_one    = c_pw'(1);
    localparam logic signed [c_aw-1:0] c_sat_max = {{(c_aw-T+1){1'b0}}, {(T-1){1'b1}}};
    localparam logic signed [c_aw-1:0] c_sat_min = {{(c_aw-T+1){1'b1}}, {(T-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_W  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_LOAD_X  = 3'd3,
        ST_COMPUTE = 3'd4,
        ST_DRAIN   = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [T-1:0]    r_w_mem [M*N];
    logic [T-1:0]    r_b_mem [M];
    logic [T-1:0]    r_x_mem [N];
    logic [c_cw-1:0] r_cnt;
    logic [c_gw-1:0] r_grp;
    logic [c_pw-1:0] r_out_idx;
    logic            r_w_loaded;
    logic [T-1:0]    r_x_op;
    logic [T-1:0]    w_res [P];
    logic            w_s_ready;
    logic            w_in_fire;
    logic            w_out_fire;

    function automatic logic [T-1:0] post_proc(input logic signed [c_aw-1:0] a);
        logic signed [c_aw-1:0] v;
        v = a;
        if (RELU != 0 && v[c_aw-1]) v = '0;
        if (SAT != 0) begin
            if (v > c_sat_max)      v = c_sat_max;
            else if (v < c_sat_min) v = c_sat_min;
        end
        return v[T-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        m_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_s_ready = cfg_load || r_w_loaded;
                if (s_valid && w_s_ready) begin
                    if (cfg_load) w_state_nxt = (M * N == 1) ? ST_LOAD_B : ST_LOAD_W;
                    else          w_state_nxt = (N == 1) ? ST_COMPUTE : ST_LOAD_X;
                end
            end
            ST_LOAD_W: begin
                w_s_ready = 1'b1;
                if (s_valid && r_cnt == c_w_last) w_state_nxt = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                w_s_ready = 1'b1;
                if (s_valid && r_cnt == c_b_last) w_state_nxt = ST_IDLE;
            end
            ST_LOAD_X: begin
                w_s_ready = 1'b1;
                if (s_valid && r_cnt == c_x_last) w_state_nxt = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (r_cnt == c_cmp_last) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                m_valid = 1'b1;
                if (m_ready && r_out_idx == c_p_last)
                    w_state_nxt = (r_grp == c_g_last) ? ST_IDLE : ST_COMPUTE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign s_ready    = w_s_ready && reset;
    assign w_in_fire  = s_valid && s_ready;
    assign w_out_fire = m_valid && m_ready;
    assign data_out   = m_valid ? w_res[r_out_idx] : '0;
    assign w_loaded   = r_w_loaded;

    // The first word of a load/x burst is taken in IDLE, so those bursts resume at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_grp      <= '0;
            r_out_idx  <= '0;
            r_w_loaded <= 1'b0;
            r_x_op     <= '0;
        end else begin
            if (w_state_nxt != r_state)
                r_cnt <= (r_state == ST_IDLE &&
                          (w_state_nxt == ST_LOAD_W || w_state_nxt == ST_LOAD_X)) ? c_cnt_one : '0;
            else if (w_in_fire || r_state == ST_COMPUTE)
                r_cnt <= r_cnt + c_cnt_one;

            if (r_state == ST_IDLE && w_in_fire && cfg_load)
                r_w_loaded <= 1'b0;
            else if (r_state == ST_LOAD_B && w_in_fire && r_cnt == c_b_last)
                r_w_loaded <= 1'b1;

            if (w_out_fire) begin
                if (r_out_idx == c_p_last) begin
                    r_out_idx <= '0;
                    r_grp     <= (r_grp == c_g_last) ? '0 : r_grp + c_g_one;
                end else begin
                    r_out_idx <= r_out_idx + c_p_one;
                end
            end

            if (r_state == ST_COMPUTE && r_cnt < c_n)
                r_x_op <= r_x_mem[c_xaw'(r_cnt)];
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_load) r_w_mem[0] <= data_in;
                    else          r_x_mem[0] <= data_in;
                end
                ST_LOAD_W: r_w_mem[c_waw'(r_cnt)] <= data_in;
                ST_LOAD_B: r_b_mem[c_baw'(r_cnt)] <= data_in;
                ST_LOAD_X: r_x_mem[c_xaw'(r_cnt)] <= data_in;
                default: ;
            endcase
        end
    end

    // Per-lane pipeline: operand fetch, registered multiply, accumulate, post-process.
    for (genvar p = 0; p < P; p++) begin : g_lane
        logic [c_waw-1:0]       w_w_addr;
        logic [c_baw-1:0]       w_b_addr;
        logic [T-1:0]           w_bias;
        logic [T-1:0]           r_w_op;
        logic [2*T-1:0]         r_prod;
        logic signed [c_aw-1:0] r_acc;
        logic [T-1:0]           r_res;

        assign w_b_addr = c_baw'(int'(r_grp) * P + p);
        assign w_w_addr = c_waw'((int'(r_grp) * P + p) * N + int'(r_cnt));
        assign w_bias   = r_b_mem[w_b_addr];
        assign w_res[p] = r_res;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_w_op <= '0;
                r_prod <= '0;
                r_acc  <= '0;
                r_res  <= '0;
            end else if (r_state == ST_COMPUTE) begin
                if (r_cnt < c_n)
                    r_w_op <= r_w_mem[w_w_addr];
                if (r_cnt >= c_cnt_one && r_cnt <= c_n)
                    r_prod <= {{T{r_w_op[T-1]}}, r_w_op} * {{T{r_x_op[T-1]}}, r_x_op};
                if (r_cnt == '0)
                    r_acc <= {{(c_aw-T){w_bias[T-1]}}, w_bias};
                else if (r_cnt >= c_cnt_two && r_cnt <= c_n1)
                    r_acc <= r_acc + {{(c_aw-2*T){r_prod[2*T-1]}}, r_prod};
                if (r_cnt == c_cmp_last)
                    r_res <= post_proc(r_acc);
            end
        end
    end

endmodule

`default_nettype wire
